// File: rtl/sc_lfsr_parallel_stream.sv
// Parallel Fibonacci LFSR: advances LANES steps per accepted transfer and streams every intermediate state.
// Optional wrap detection (wrap pulse + saturating wrap_cnt) is built when SC_LFSR_WRAP_DET_EN is defined.
module sc_lfsr_parallel_stream #(
  parameter int               WIDTH = 8,
  parameter int               LANES = 4,
  parameter logic [WIDTH-1:0] TAPS  = 8'hC0,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     load,
  input  logic [WIDTH-1:0]         seed_in,
  input  logic                     ready,
  output logic                     valid,
  output logic [LANES*WIDTH-1:0]   lane_out,
  output logic [WIDTH-1:0]         state_out,
  output logic                     seed_err,
  output logic                     wrap,
  output logic [15:0]              wrap_cnt
);

  localparam int LW = LANES * WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic             r_valid;
  logic [LW-1:0]    r_lane;
  logic             r_seed_err;

  logic [LW-1:0]    w_lanes;
  logic [WIDTH-1:0] w_walk;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_load_seed;
  logic             w_advance;

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latch).
  always_comb begin
    w_lanes = '0;
    w_walk  = r_state;
    for (int k = 0; k < LANES; k++) begin
      w_walk = f_step(w_walk);
      w_lanes[k*WIDTH +: WIDTH] = w_walk;
    end
  end

  assign w_last      = w_lanes[(LANES-1)*WIDTH +: WIDTH];
  assign w_load_seed = (seed_in == '0) ? SEED : seed_in;
  // IDLE always has valid low, so one condition covers both the IDLE start and RUN continuation.
  assign w_advance   = !load && en && (!r_valid || ready);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_state    <= SEED;
      r_valid    <= 1'b0;
      r_lane     <= '0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= 1'b0;
      if (load) begin
        r_state    <= w_load_seed;
        r_valid    <= 1'b0;
        r_seed_err <= (seed_in == '0);
        r_fsm      <= S_IDLE;
      end else if (w_advance) begin
        r_lane  <= w_lanes;
        r_state <= w_last;
        r_valid <= 1'b1;
        r_fsm   <= S_RUN;
      end else if (r_fsm == S_RUN && (!r_valid || ready)) begin
        r_valid <= 1'b0;
        r_fsm   <= S_IDLE;
      end
    end
  end

  assign valid     = r_valid;
  assign lane_out  = r_lane;
  assign state_out = r_state;
  assign seed_err  = r_seed_err;

`ifdef SC_LFSR_WRAP_DET_EN
  logic [WIDTH-1:0] r_seed;
  logic             r_wrap;
  logic [15:0]      r_wrap_cnt;
  logic             w_hit;

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (w_lanes[k*WIDTH +: WIDTH] == r_seed) w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed     <= SEED;
      r_wrap     <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_seed     <= w_load_seed;
        r_wrap_cnt <= '0;
      end else if (w_advance && w_hit) begin
        r_wrap <= 1'b1;
        if (r_wrap_cnt != 16'hFFFF) r_wrap_cnt <= r_wrap_cnt + 16'd1;
      end
    end
  end

  assign wrap     = r_wrap;
  assign wrap_cnt = r_wrap_cnt;
`else
  assign wrap     = 1'b0;
  assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_sc_lfsr_parallel_stream.sv
// Self-checking bench: default 8-bit instance plus a 4-bit/3-lane instance, both checked every cycle against a stream model.
module tb_sc_lfsr_parallel_stream;

`ifdef SC_LFSR_WRAP_DET_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int AW = 8, AL = 4;
  localparam int BW = 4, BL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_en, a_load, a_ready, a_valid, a_seed_err, a_wrap;
  logic [AW-1:0] a_seed_in, a_state;
  logic [AW*AL-1:0] a_lane;
  logic [15:0]   a_wrap_cnt;

  logic          b_en, b_load, b_ready, b_valid, b_seed_err, b_wrap;
  logic [BW-1:0] b_seed_in, b_state;
  logic [BW*BL-1:0] b_lane;
  logic [15:0]   b_wrap_cnt;

  sc_lfsr_parallel_stream u_a (
    .clk(clk), .reset(reset), .en(a_en), .load(a_load), .seed_in(a_seed_in), .ready(a_ready),
    .valid(a_valid), .lane_out(a_lane), .state_out(a_state), .seed_err(a_seed_err),
    .wrap(a_wrap), .wrap_cnt(a_wrap_cnt)
  );

  sc_lfsr_parallel_stream #(.WIDTH(BW), .LANES(BL), .TAPS(4'hC), .SEED(4'h1)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .load(b_load), .seed_in(b_seed_in), .ready(b_ready),
    .valid(b_valid), .lane_out(b_lane), .state_out(b_state), .seed_err(b_seed_err),
    .wrap(b_wrap), .wrap_cnt(b_wrap_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: what the consumer should see, derived from the stepping rule and handshake rules.
  typedef struct packed {
    logic [31:0] state;
    logic        valid;
    logic [63:0] lanes;
    logic [31:0] seed;
    logic        seed_err;
    logic        wrap;
    logic [31:0] wrap_cnt;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int nxt(input int s, input int w, input int taps);
    return ((s << 1) & ((1 << w) - 1)) | ($countones(s & taps) % 2);
  endfunction

  function automatic mdl_t mdl_reset(input int seed);
    mdl_t m;
    m.state = seed; m.valid = 1'b0; m.lanes = '0; m.seed = seed;
    m.seed_err = 1'b0; m.wrap = 1'b0; m.wrap_cnt = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_cycle(input mdl_t m, input int w, input int l, input int taps,
                                     input int seed0, input bit en, input bit load,
                                     input int seed_in, input bit ready);
    mdl_t n;
    int   s;
    n = m;
    n.seed_err = 1'b0;
    n.wrap     = 1'b0;
    if (load) begin
      s = (seed_in == 0) ? seed0 : seed_in;
      n.seed_err = (seed_in == 0);
      n.state = s; n.seed = s; n.valid = 1'b0; n.wrap_cnt = '0;
    end else if (!m.valid || ready) begin
      if (en) begin
        s = m.state;
        n.lanes = '0;
        for (int k = 0; k < l; k++) begin
          s = nxt(s, w, taps);
          n.lanes = n.lanes | (64'(s) << (k * w));
          if (s == m.seed) n.wrap = WRAP_EN;
        end
        n.state = s;
        n.valid = 1'b1;
        if (n.wrap && n.wrap_cnt < 65535) n.wrap_cnt = n.wrap_cnt + 1;
      end else begin
        n.valid = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma = mdl_reset(1);
      mb = mdl_reset(1);
    end else begin
      ma = mdl_cycle(ma, AW, AL, 'hC0, 1, a_en, a_load, int'(a_seed_in), a_ready);
      mb = mdl_cycle(mb, BW, BL, 'hC, 1, b_en, b_load, int'(b_seed_in), b_ready);
    end
  end

  always @(negedge clk) begin
    check("a_valid", a_valid, ma.valid);
    if (ma.valid) check("a_lane", a_lane, ma.lanes[AW*AL-1:0]);
    check("a_state", a_state, ma.state[AW-1:0]);
    check("a_seed_err", a_seed_err, ma.seed_err);
    check("a_wrap", a_wrap, ma.wrap);
    check("a_wrap_cnt", a_wrap_cnt, ma.wrap_cnt[15:0]);
    check("b_valid", b_valid, mb.valid);
    if (mb.valid) check("b_lane", b_lane, mb.lanes[BW*BL-1:0]);
    check("b_state", b_state, mb.state[BW-1:0]);
    check("b_seed_err", b_seed_err, mb.seed_err);
    check("b_wrap", b_wrap, mb.wrap);
    check("b_wrap_cnt", b_wrap_cnt, mb.wrap_cnt[15:0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] B_WORDS [5] = '{12'h942, 12'hD63, 12'hB5A, 12'hEF7, 12'h18C};

  initial begin
    a_en = 1'b0; a_load = 1'b0; a_ready = 1'b0; a_seed_in = '0;
    b_en = 1'b0; b_load = 1'b0; b_ready = 1'b0; b_seed_in = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) cyc();
    check("rst_valid", a_valid, 1'b0);
    check("rst_lane", a_lane, 32'h0);
    check("rst_state", a_state, 8'h01);
    check("rst_seed_err", a_seed_err, 1'b0);
    check("rst_wrap", a_wrap, 1'b0);
    check("rst_wrap_cnt", a_wrap_cnt, 16'h0);
    check("rst_b_state", b_state, 4'h1);

    // Free-running stream from the reset seed
    reset = 1'b0; a_en = 1'b1; a_ready = 1'b1;
    cyc();
    check("t1_w1_lane", a_lane, 32'h10080402);
    check("t1_w1_state", a_state, 8'h10);
    check("t1_w1_valid", a_valid, 1'b1);
    cyc();
    check("t1_w2_lane", a_lane, 32'h03814020);
    check("t1_w2_state", a_state, 8'h03);

    // Back-pressure holds the first word
    a_load = 1'b1; a_seed_in = 8'h01; a_en = 1'b0;
    cyc();
    check("t2_load_valid", a_valid, 1'b0);
    check("t2_load_state", a_state, 8'h01);
    a_load = 1'b0; a_en = 1'b1;
    cyc();
    check("t2_w1_lane", a_lane, 32'h10080402);
    a_ready = 1'b0;
    repeat (5) begin
      cyc();
      check("t2_stall_lane", a_lane, 32'h10080402);
      check("t2_stall_state", a_state, 8'h10);
      check("t2_stall_valid", a_valid, 1'b1);
    end
    a_ready = 1'b1;
    cyc();
    check("t2_w2_lane", a_lane, 32'h03814020);

    // Zero seed falls back to SEED and flags it
    a_load = 1'b1; a_seed_in = 8'h00;
    cyc();
    check("t3_seed_err", a_seed_err, 1'b1);
    check("t3_state", a_state, 8'h01);
    check("t3_valid", a_valid, 1'b0);
    a_load = 1'b0; a_en = 1'b0;
    cyc();
    check("t3_seed_err_clr", a_seed_err, 1'b0);

    // Load beats a pending word
    a_en = 1'b1; a_ready = 1'b0;
    cyc();
    check("t4_pending", a_valid, 1'b1);
    a_load = 1'b1; a_seed_in = 8'h5A; a_ready = 1'b1;
    cyc();
    check("t4_valid", a_valid, 1'b0);
    check("t4_state", a_state, 8'h5A);
    check("t4_seed_err", a_seed_err, 1'b0);
    a_load = 1'b0;
    cyc();
    check("t4_w1_lane", a_lane, 32'hAED76BB5);
    check("t4_w1_state", a_state, 8'hAE);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", a_valid, 1'b0);
    check("mid_rst_lane", a_lane, 32'h0);
    check("mid_rst_state", a_state, 8'h01);
    cyc();
    reset = 1'b0; a_en = 1'b0;

    // Small configuration: period-15 sequence, wraps every fifth word
    b_en = 1'b1; b_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (i <= 5) check("t5_b_lane", b_lane, B_WORDS[i-1]);
      check("t5_b_wrap", b_wrap, WRAP_EN && (i % 5 == 0));
    end
    check("t5_b_wrap_cnt", b_wrap_cnt, WRAP_EN ? 16'd3 : 16'd0);
    check("t5_b_state", b_state, 4'h1);
    b_load = 1'b1; b_seed_in = 4'h0;
    cyc();
    check("t5_b_seed_err", b_seed_err, 1'b1);
    check("t5_b_cnt_clr", b_wrap_cnt, 16'h0);
    b_load = 1'b0;

    // Random traffic on both instances
    repeat (3000) begin
      a_en      = ($urandom_range(0, 3) != 0);
      a_ready   = ($urandom_range(0, 9) < 7);
      a_load    = ($urandom_range(0, 19) == 0);
      a_seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      b_en      = ($urandom_range(0, 3) != 0);
      b_ready   = ($urandom_range(0, 9) < 7);
      b_load    = ($urandom_range(0, 29) == 0);
      b_seed_in = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
